// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller for the RAT CPU: synchronises and edge-detects IRQ lines,
// latches them as pending, masks them and hands one fixed-priority winner to the control unit.
module rat_intr_ctrl #(
  parameter int unsigned          N_SRC     = 4,
  parameter int unsigned          VEC_W     = 10,
  parameter logic [VEC_W-1:0]     VEC_BASE  = 10'h3F8,
  parameter logic [7:0]           MASK_PORT = 8'h30,
  parameter logic [7:0]           CLR_PORT  = 8'h31,
  parameter logic [7:0]           STAT_PORT = 8'h32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic             I_EN,
  input  logic             INTR_ACK,
  input  logic             RETI,
  input  logic             IO_STRB,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  output logic             INTR,
  output logic [VEC_W-1:0] INT_VECTOR,
  output logic [7:0]       PEND_STAT,
  output logic [2:0]       ACTIVE_ID
);

  typedef enum logic [1:0] {StIdle, StReq, StSvc} state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_s1, r_s2, r_s3;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [2:0]       r_act_id;
  logic [VEC_W-1:0] r_vec;
  logic             r_intr;
  logic             r_in_svc;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_act_oh;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_port_clr;
  logic [2:0]       w_win_id;
  logic             w_act_pend;
  logic             w_mask_wr;
  logic             w_clr_wr;
  logic [7:0]       w_pend8;
  logic             w_unused;

  // STAT_PORT only qualifies the CPU-side IN mux; OUT_PORT bits above N_SRC carry nothing.
  assign w_unused = ^{OUT_PORT, STAT_PORT};

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= IRQ_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_s3;
  assign w_elig     = r_pend & r_mask;
  assign w_mask_wr  = IO_STRB && (PORT_ID == MASK_PORT);
  assign w_clr_wr   = IO_STRB && (PORT_ID == CLR_PORT);
  assign w_port_clr = w_clr_wr ? OUT_PORT[N_SRC-1:0] : '0;

  // Lowest index wins.
  always_comb begin
    w_win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = 3'(i);
    end
  end

  always_comb begin
    w_act_oh = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_act_oh[i] = (r_act_id == 3'(i));
    end
  end

  assign w_act_pend = |(r_pend & w_act_oh);
  assign w_ack_clr  = ((r_state == StReq) && INTR_ACK) ? w_act_oh : '0;

  // A new edge overrides any clear landing on the same bit in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_port_clr | w_ack_clr)) | w_edge;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mask <= '0;
    end else if (w_mask_wr) begin
      r_mask <= OUT_PORT[N_SRC-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_intr   <= 1'b0;
      r_in_svc <= 1'b0;
      r_act_id <= '0;
      r_vec    <= VEC_BASE;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (I_EN && (|w_elig)) begin
            r_state  <= StReq;
            r_intr   <= 1'b1;
            r_act_id <= w_win_id;
            r_vec    <= VEC_BASE + VEC_W'(w_win_id);
          end
        end
        StReq: begin
          if (INTR_ACK) begin
            r_state  <= StSvc;
            r_intr   <= 1'b0;
            r_in_svc <= 1'b1;
          end else if (!I_EN || !w_act_pend) begin
            r_state <= StIdle;
            r_intr  <= 1'b0;
          end
        end
        StSvc: begin
          if (RETI) begin
            r_state  <= StIdle;
            r_in_svc <= 1'b0;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_intr   <= 1'b0;
          r_in_svc <= 1'b0;
        end
      endcase
    end
  end

  // Bit 7 is reserved for in_service, so with eight sources pending[7] is not reported.
  assign w_pend8    = 8'(r_pend);
  assign PEND_STAT  = {r_in_svc, w_pend8[6:0]};
  assign INTR       = r_intr;
  assign INT_VECTOR = r_vec;
  assign ACTIVE_ID  = r_act_id;

endmodule
